mul_sequencer: RTL and testbench

- Front-end for the non-pipelined 32-bit multicycle multiplier (low-32 product, req/ack handshake).
- Accepts tagged operand pairs from the execute stage over valid/ready and buffers them in a small FIFO.
- Issues them one at a time as single-cycle req pulses, holding the operands stable until ack.
- Returns each product with its tag over a valid/ready result port; includes a stall-timeout error path.

---
 rtl/mul_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_mul_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer
// Front-end for a non-pipelined 32-bit multicycle multiplier. It buffers
// tagged operand pairs in a small FIFO. It issues each pair to the
// multiplier as a one-cycle req pulse and keeps the operands stable until
// the ack arrives. It then returns the low 32 bits of the product, with the
// tag, on a result port. If no valid ack arrives in time, it returns an
// error result instead.
//
// Handshake semantics (both in_* and res_* ports): a transfer happens on a
// rising edge where valid=1 and ready=1. A producer that raises valid keeps
// valid and its payload stable until that transfer happens.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   operand pair offered
//   in_ready   FIFO not full
//   in_a/in_b  multiplicand / multiplier
//   in_tag     request tag
//   mul_req    one-cycle start pulse to the multiplier
//   mul_p0/p1  operands to the multiplier, held through the whole operation
//   mul_ack    multiplier done pulse
//   mul_out    multiplier product, valid while mul_ack=1
//   res_valid  result available
//   res_ready  consumer accepts the result
//   res_data   low 32 bits of a*b (0 on timeout)
//   res_tag    tag of the result
//   res_err    result produced by timeout
//   busy       FIFO non-empty or FSM not IDLE
//   dbg_state  current FSM state (IDLE=0, ISSUE=1, WAIT=2, HOLD=3)
module mul_sequencer #(
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_req,
  output logic [31:0]      mul_p0,
  output logic [31:0]      mul_p1,
  input  logic             mul_ack,
  input  logic [31:0]      mul_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // Operand FIFO storage
  logic [31:0]      a_mem   [DEPTH];
  logic [31:0]      b_mem   [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  logic [1:0]       state_q,  state_d;
  logic [TCW-1:0]   cnt_q,    cnt_d;
  logic [TAG_W-1:0] tag_q,    tag_d;

  logic             mul_req_q,   mul_req_d;
  logic [31:0]      p0_q,        p0_d;
  logic [31:0]      p1_q,        p1_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q,  res_data_d;
  logic [TAG_W-1:0] res_tag_q,   res_tag_d;
  logic             res_err_q,   res_err_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             avail;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic [TAG_W-1:0] head_tag;
  logic             ack_ok;
  logic             timeout_hit;

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != CW'(DEPTH));
  assign push       = in_valid && in_ready;

  // An operand arriving at an empty FIFO can be issued in the same cycle. The
  // slot is still written and both pointers advance, so the count stays
  // unchanged, but the head comes straight from the input pins.
  assign avail    = !fifo_empty || push;
  assign head_a   = fifo_empty ? in_a   : a_mem[rd_ptr_q];
  assign head_b   = fifo_empty ? in_b   : b_mem[rd_ptr_q];
  assign head_tag = fifo_empty ? in_tag : tag_mem[rd_ptr_q];

  // Acks seen in the first three WAIT cycles can only be stale leftovers
  // from an operation that a reset aborted, so they are ignored.
  assign ack_ok      = mul_ack && (cnt_q >= TCW'(3));
  assign timeout_hit = (cnt_q == TCW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    mul_req_d   = 1'b0;
    p0_d        = p0_q;
    p1_d        = p1_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (avail) begin
          state_d   = ISSUE;
          mul_req_d = 1'b1;
          p0_d      = head_a;
          p1_d      = head_b;
          tag_d     = head_tag;
          pop       = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + TCW'(1);
        if (ack_ok) begin
          state_d     = HOLD;
          res_valid_d = 1'b1;
          res_data_d  = mul_out;
          res_tag_d   = tag_q;
          res_err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d     = HOLD;
          res_valid_d = 1'b1;
          res_data_d  = '0;
          res_tag_d   = tag_q;
          res_err_d   = 1'b1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (avail) begin
            state_d   = ISSUE;
            mul_req_d = 1'b1;
            p0_d      = head_a;
            p1_d      = head_b;
            tag_d     = head_tag;
            pop       = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Storage needs no reset: the count decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_q]   <= in_a;
      b_mem[wr_ptr_q]   <= in_b;
      tag_mem[wr_ptr_q] <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      tag_q       <= '0;
      mul_req_q   <= 1'b0;
      p0_q        <= '0;
      p1_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      mul_req_q   <= mul_req_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
    end
  end

  assign mul_req   = mul_req_q;
  assign mul_p0    = p0_q;
  assign mul_p1    = p1_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign res_err   = res_err_q;
  assign busy      = !fifo_empty || (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed testbench for mul_sequencer. A behavioural multiplier stub acks
// four cycles after each req, using the operands present at ack time. It can
// be disabled (to force a timeout) or made to inject a stale ack.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        mul_req;
  logic [31:0] mul_p0;
  logic [31:0] mul_p1;
  logic        mul_ack = 1'b0;
  logic [31:0] mul_out = '0;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic        res_err;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_tag_q[$];

  // Stub controls
  bit stub_en  = 1'b1;
  int inj_req  = 0;
  int inj_seen = 0;
  int stub_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mul_sequencer #(.TAG_W(4), .DEPTH(2), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .mul_req   (mul_req),
    .mul_p0    (mul_p0),
    .mul_p1    (mul_p1),
    .mul_ack   (mul_ack),
    .mul_out   (mul_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag),
    .res_err   (res_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Multiplier stub. It works on the falling edge, so ack is stable when the
  // DUT samples it. A req seen in cycle R produces ack in cycle R+4.
  always @(negedge clk) begin
    mul_ack = 1'b0;
    if (inj_seen != inj_req) begin
      inj_seen = inj_req;
      mul_ack  = 1'b1;
      mul_out  = 32'hDEAD_BEEF;
    end
    if (mul_req) begin
      stub_cnt = 4;
    end else if (stub_cnt != 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0 && stub_en) begin
        mul_ack = 1'b1;
        mul_out = mul_p0 * mul_p1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Offers one operand and returns in the cycle after it was taken.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int g;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 60) begin
      tick();
      g++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int bound);
    int g;
    g = 0;
    while (!res_valid && g < bound) begin
      tick();
      g++;
    end
    check("res_valid_wait", {31'b0, res_valid}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    res_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_mul_req",   {31'b0, mul_req},   32'd0);
    check("rst_mul_p0",    mul_p0,             32'd0);
    check("rst_mul_p1",    mul_p1,             32'd0);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_res_data",  res_data,           32'd0);
    check("rst_res_tag",   {28'b0, res_tag},   32'd0);
    check("rst_res_err",   {31'b0, res_err},   32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    rst = 1'b1;
    tick();
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_state",     {30'b0, dbg_state}, 32'd0);

    // Single op with exact latency: accepted in A, req in A+1, result in A+6
    do_op(32'd3, 32'd5, 4'd2);
    check("single_req_a1", {31'b0, mul_req}, 32'd1);
    check("single_p0",     mul_p0,           32'd3);
    check("single_p1",     mul_p1,           32'd5);
    check("single_busy",   {31'b0, busy},    32'd1);
    tick();
    check("single_req_a2", {31'b0, mul_req}, 32'd0);
    tick(); tick(); tick();
    check("single_valid_a5", {31'b0, res_valid}, 32'd0);
    tick();
    check("single_valid_a6", {31'b0, res_valid}, 32'd1);
    check("single_data",     res_data,           32'd15);
    check("single_tag",      {28'b0, res_tag},   32'd2);
    check("single_err",      {31'b0, res_err},   32'd0);
    tick();
    check("single_drop",     {31'b0, res_valid}, 32'd0);
    check("single_idle",     {31'b0, busy},      32'd0);

    // Wrap-around products
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd8);
    wait_res(20);
    check("wrap1_data", res_data,         32'h0000_0001);
    check("wrap1_tag",  {28'b0, res_tag}, 32'd8);
    tick();
    do_op(32'h0001_0000, 32'h0001_0000, 4'd9);
    wait_res(20);
    check("wrap2_data", res_data,         32'h0000_0000);
    check("wrap2_err",  {31'b0, res_err}, 32'd0);
    tick();
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 4'd10);
    wait_res(20);
    check("wrap3_data", res_data,         32'h242D_2080);
    check("wrap3_tag",  {28'b0, res_tag}, 32'd10);
    tick();

    // Backpressure: three ops with the consumer stalled
    res_ready = 1'b0;
    exp_q.push_back(32'd42);      exp_tag_q.push_back(32'd1);
    exp_q.push_back(32'h0003_0000); exp_tag_q.push_back(32'd2);
    exp_q.push_back(32'd10000);   exp_tag_q.push_back(32'd3);
    do_op(32'd7, 32'd6, 4'd1);
    do_op(32'h0001_0000, 32'd3, 4'd2);
    do_op(32'd100, 32'd100, 4'd3);
    check("bp_full",     {31'b0, in_ready}, 32'd0);
    check("bp_p0_hold1", mul_p0,            32'd7);
    check("bp_p1_hold1", mul_p1,            32'd6);
    tick(); tick();
    check("bp_p0_hold2", mul_p0,            32'd7);
    check("bp_p1_hold2", mul_p1,            32'd6);
    wait_res(20);
    tick(); tick(); tick();
    check("bp_held_valid", {31'b0, res_valid}, 32'd1);
    check("bp_held_data",  res_data,           32'd42);
    check("bp_no_issue",   {31'b0, mul_req},   32'd0);
    check("bp_still_full", {31'b0, in_ready},  32'd0);
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_res(20);
      check("bp_data", res_data,         exp_q.pop_front());
      check("bp_tag",  {28'b0, res_tag}, exp_tag_q.pop_front());
      check("bp_err",  {31'b0, res_err}, 32'd0);
      tick();
    end
    check("bp_drained", {31'b0, busy}, 32'd0);

    // Timeout: the stub never acks; error result after 16 WAIT cycles
    stub_en = 1'b0;
    do_op(32'd11, 32'd13, 4'd5);
    repeat (16) tick();
    check("to_not_yet", {31'b0, res_valid}, 32'd0);
    tick();
    check("to_valid",   {31'b0, res_valid}, 32'd1);
    check("to_err",     {31'b0, res_err},   32'd1);
    check("to_data",    res_data,           32'd0);
    check("to_tag",     {28'b0, res_tag},   32'd5);
    tick();
    stub_en = 1'b1;
    do_op(32'd2, 32'd21, 4'd6);
    wait_res(20);
    check("to_next_data", res_data,         32'd42);
    check("to_next_err",  {31'b0, res_err}, 32'd0);
    check("to_next_tag",  {28'b0, res_tag}, 32'd6);
    tick();

    // Stale acks: one in IDLE, one at WAIT counter=1
    inj_req++;
    tick(); tick();
    check("stale_idle_valid", {31'b0, res_valid}, 32'd0);
    check("stale_idle_busy",  {31'b0, busy},      32'd0);
    do_op(32'd9, 32'd9, 4'd7);
    tick(); tick();
    inj_req++;
    tick();
    check("stale_wait_valid", {31'b0, res_valid}, 32'd0);
    wait_res(20);
    check("stale_data", res_data,         32'd81);
    check("stale_tag",  {28'b0, res_tag}, 32'd7);
    tick();

    // Async reset in the middle of WAIT
    do_op(32'd5, 32'd5, 4'd12);
    tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_req",   {31'b0, mul_req},   32'd0);
    check("arst_p0",    mul_p0,             32'd0);
    check("arst_p1",    mul_p1,             32'd0);
    check("arst_busy",  {31'b0, busy},      32'd0);
    check("arst_valid", {31'b0, res_valid}, 32'd0);
    tick();
    rst = 1'b1;
    repeat (8) tick();
    check("arst_late_ack_valid", {31'b0, res_valid}, 32'd0);
    check("arst_late_ack_busy",  {31'b0, busy},      32'd0);
    do_op(32'd6, 32'd7, 4'd4);
    wait_res(20);
    check("arst_next_data", res_data,         32'd42);
    check("arst_next_tag",  {28'b0, res_tag}, 32'd4);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
